cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's fixed 4-bit combinational CLA.
- Splits a WIDTH-bit operation into WIDTH/GROUP lookahead groups and registers the ripple between groups, one group per stage, so wide adds close timing.
- Valid/ready streaming interface with backpressure; sits between operand sources and arithmetic consumers in the datapath.

---
 rtl/cla_pipe_adder.sv | 132 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// with a registered group carry between stages and a valid/ready stream wrapper.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned GS = (GROUP == 0) ? 1 : GROUP;
    localparam int unsigned NG = ((WIDTH / GS) == 0) ? 1 : (WIDTH / GS);

    if ((GROUP == 0) || ((WIDTH % GS) != 0)) begin : g_bad_params
        $fatal(1, "cla_pipe_adder: WIDTH=%0d must be a multiple of GROUP=%0d (GROUP >= 1)",
               WIDTH, GROUP);
    end

    // Group carries as flat sum-of-products: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
    function automatic logic [GS:0] lookahead(input logic [GS-1:0] p,
                                              input logic [GS-1:0] g,
                                              input logic          ci);
        logic [GS:0] c;
        logic        acc;
        logic        term;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < GS; i++) begin
            acc = ci;
            for (int unsigned m = 0; m <= i; m++) acc = acc & p[m];
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        return c;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    logic [NG-1:0]            v_q;
    logic [NG-1:0]            c_q;
    logic [NG-1:0]            o_q;
    logic [NG-1:0][WIDTH-1:0] a_q;
    logic [NG-1:0][WIDTH-1:0] b_q;
    logic [NG-1:0][WIDTH-1:0] s_q;

    assign adv     = out_ready | ~out_valid;
    assign in_ready = adv;
    assign b_eff   = sub ? ~b : b;
    assign c_first = sub | cin;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        localparam int unsigned LO = int'(k) * GS;

        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nx;
        logic [GS-1:0]    p;
        logic [GS-1:0]    g;
        logic [GS:0]      cv;

        if (k == 0) begin : g_src
            assign v_in = in_valid;
            assign a_in = a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = c_first;
        end else begin : g_src
            assign v_in = v_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
        end

        // Resolve this stage's slice; lower slices pass through untouched
        always_comb begin
            p    = a_in[LO +: GS] ^ b_in[LO +: GS];
            g    = a_in[LO +: GS] & b_in[LO +: GS];
            cv   = lookahead(p, g, c_in);
            s_nx = s_in;
            s_nx[LO +: GS] = p ^ cv[GS-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
            end else if (adv) begin
                v_q[k] <= v_in;
                a_q[k] <= a_in;
                b_q[k] <= b_in;
                s_q[k] <= s_nx;
                c_q[k] <= cv[GS];
                o_q[k] <= cv[GS] ^ cv[GS-1];
            end
        end
    end

    // Last-stage operand copies and non-final overflow bits have no consumer
    logic unused_bits;
    assign unused_bits = ^{a_q[NG-1], b_q[NG-1], o_q};

    assign out_valid = v_q[NG-1];
    assign sum       = s_q[NG-1];
    assign cout      = c_q[NG-1];
    assign ovf       = o_q[NG-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized checks for cla_pipe_adder, including a small parameter sweep.
module tb_cla_pipe_adder;

    localparam int unsigned NG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    logic [31:0] sa, sb;
    logic        scin, ssub, svalid, sordy;
    logic [3:0]  s_ir, s_ov, s_co, s_of;
    logic [3:0]  s0_sum;
    logic [7:0]  s1_sum;
    logic [31:0] s2_sum;
    logic [11:0] s3_sum;
    logic [31:0] s_sum [4];

    assign s_sum[0] = 32'(s0_sum);
    assign s_sum[1] = 32'(s1_sum);
    assign s_sum[2] = s2_sum;
    assign s_sum[3] = 32'(s3_sum);

    cla_pipe_adder #(.WIDTH(4), .GROUP(4)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(svalid), .in_ready(s_ir[0]),
        .a(sa[3:0]), .b(sb[3:0]), .cin(scin), .sub(ssub), .out_valid(s_ov[0]),
        .out_ready(sordy), .sum(s0_sum), .cout(s_co[0]), .ovf(s_of[0]));
    cla_pipe_adder #(.WIDTH(8), .GROUP(2)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(svalid), .in_ready(s_ir[1]),
        .a(sa[7:0]), .b(sb[7:0]), .cin(scin), .sub(ssub), .out_valid(s_ov[1]),
        .out_ready(sordy), .sum(s1_sum), .cout(s_co[1]), .ovf(s_of[1]));
    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(svalid), .in_ready(s_ir[2]),
        .a(sa), .b(sb), .cin(scin), .sub(ssub), .out_valid(s_ov[2]),
        .out_ready(sordy), .sum(s2_sum), .cout(s_co[2]), .ovf(s_of[2]));
    cla_pipe_adder #(.WIDTH(12), .GROUP(1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(svalid), .in_ready(s_ir[3]),
        .a(sa[11:0]), .b(sb[11:0]), .cin(scin), .sub(ssub), .out_valid(s_ov[3]),
        .out_ready(sordy), .sum(s3_sum), .cout(s_co[3]), .ovf(s_of[3]));

    // Reference: {ovf, cout, sum[31:0]} for a w-bit add/subtract using plain integer arithmetic
    function automatic logic [33:0] model(input int unsigned w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci, input logic sb_);
        logic [32:0] mask;
        logic [32:0] full;
        logic [31:0] xm, ye, s;
        logic        co, ov;
        mask = (33'd1 << w) - 33'd1;
        xm   = x & mask[31:0];
        ye   = (sb_ ? ~y : y) & mask[31:0];
        full = {1'b0, xm} + {1'b0, ye} + {32'd0, (sb_ | ci)};
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (xm[w-1] == ye[w-1]) && (s[w-1] != xm[w-1]);
        return {ov, co, s};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (sum !== 16'h0) begin bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
        total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {cout, ovf}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // fill the pipe, then reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'(i + 1); b = 16'h0001; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fill_valid: got %b want 1", out_valid); end
        #2; rst_n = 1'b0; #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        total++; if (sum !== 16'h0) begin bad++; $display("FAIL midrst_sum: got %h want 0000", sum); end
        total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL midrst_flags: got %b want 00", {cout, ovf}); end
        out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stale_beat: cycle %0d got %b want 0", t, out_valid); end
        end
    endtask

    task automatic test_carry();
        logic [15:0] va [2] = '{16'hFFFF, 16'h7FFF};
        logic [15:0] es [2] = '{16'h0000, 16'h8000};
        logic [1:0]  ef [2] = '{2'b10, 2'b01};
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            a = va[v]; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int t = 1; t <= NG; t++) begin
                if (t > 1) begin @(posedge clk); #1; end
                total++;
                if (out_valid !== (t == NG)) begin bad++; $display("FAIL carry_latency: vec %0d cycle %0d got %b want %b", v, t, out_valid, (t == NG)); end
            end
            total++; if (sum !== es[v]) begin bad++; $display("FAIL carry_sum: vec %0d got %h want %h", v, sum, es[v]); end
            total++; if ({cout, ovf} !== ef[v]) begin bad++; $display("FAIL carry_flags: vec %0d got %b want %b", v, {cout, ovf}, ef[v]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [2] = '{16'h0005, 16'h8000};
        logic [15:0] vb [2] = '{16'h0007, 16'h0001};
        logic [15:0] es [2] = '{16'hFFFE, 16'h7FFF};
        logic [1:0]  ef [2] = '{2'b00, 2'b11};
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            a = va[v]; b = vb[v]; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int t = 1; t <= NG; t++) begin
                if (t > 1) begin @(posedge clk); #1; end
                total++;
                if (out_valid !== (t == NG)) begin bad++; $display("FAIL sub_latency: vec %0d cycle %0d got %b want %b", v, t, out_valid, (t == NG)); end
            end
            total++; if (sum !== es[v]) begin bad++; $display("FAIL sub_sum: vec %0d got %h want %h", v, sum, es[v]); end
            total++; if ({cout, ovf} !== ef[v]) begin bad++; $display("FAIL sub_flags: vec %0d got %b want %b", v, {cout, ovf}, ef[v]); end
            @(posedge clk); #1;
        end
        sub = 1'b0; cin = 1'b0;
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        cin = 1'b0; sub = 1'b0;
        for (int t = 0; t < 60 && got < 8; t++) begin
            out_ready = !(t >= 5 && t <= 9);
            in_valid  = (sent < 8);
            a = 16'(sent); b = 16'(3 * sent);
            #1;
            if (t >= 5 && t <= 9) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: cycle %0d got %b want 0", t, in_ready); end
            end
            if (out_valid) begin
                total++;
                if ({ovf, cout, sum} !== {2'b00, 16'(4 * got)}) begin
                    bad++; $display("FAIL bp_data: cycle %0d got %h/%b%b want %h/00", t, sum, cout, ovf, 16'(4 * got));
                end
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== 8) begin bad++; $display("FAIL bp_count: got %0d beats want 8", got); end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [17:0] q [$];
        logic [33:0] e;
        logic [17:0] h;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 80000 && (sent < N || got < sent); cyc++) begin
            in_valid  = (sent < N) && ($urandom_range(0, 1) == 1);
            out_ready = (sent >= N) || ($urandom_range(0, 1) == 1);
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra: unexpected beat sum=%h", sum);
                end else begin
                    h = q.pop_front();
                    if ({ovf, cout, sum} !== h) begin
                        bad++; $display("FAIL rand_data: beat %0d got %h want %h", got, {ovf, cout, sum}, h);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                e = model(16, 32'(a), 32'(b), cin, sub);
                q.push_back({e[33], e[32], e[15:0]});
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== N || q.size() != 0) begin bad++; $display("FAIL rand_count: got %0d beats want %0d", got, N); end
    endtask

    task automatic test_sweep();
        int unsigned sw_w   [4] = '{4, 8, 32, 12};
        int          sw_lat [4] = '{1, 4, 4, 12};
        logic [33:0] exp_v  [4];
        logic [33:0] act;
        sordy = 1'b1; svalid = 1'b0;
        for (int v = 0; v < 20; v++) begin
            if (v == 0) begin
                sa = 32'hFFFF_FFFF; sb = 32'h1; scin = 1'b0; ssub = 1'b0;
            end else begin
                sa = $urandom; sb = $urandom;
                scin = 1'($urandom_range(0, 1)); ssub = 1'($urandom_range(0, 1));
            end
            svalid = 1'b1;
            #1;
            total++; if (s_ir !== 4'hF) begin bad++; $display("FAIL sweep_ready: got %b want 1111", s_ir); end
            for (int i = 0; i < 4; i++) exp_v[i] = model(sw_w[i], sa, sb, scin, ssub);
            @(posedge clk); #1;
            svalid = 1'b0;
            for (int t = 1; t <= 13; t++) begin
                for (int i = 0; i < 4; i++) begin
                    total++;
                    if (s_ov[i] !== (t == sw_lat[i])) begin
                        bad++; $display("FAIL sweep_latency: inst %0d cycle %0d got %b want %b", i, t, s_ov[i], (t == sw_lat[i]));
                    end
                    if (t == sw_lat[i]) begin
                        act = {s_of[i], s_co[i], s_sum[i]};
                        total++;
                        if (act !== exp_v[i]) begin
                            bad++; $display("FAIL sweep_data: inst %0d vec %0d got %h want %h", i, v, act, exp_v[i]);
                        end
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0; svalid = 1'b0; sordy = 1'b1;
        test_reset();
        test_carry();
        test_sub();
        test_backpressure();
        test_random();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
